// File: rtl/conv_loop_sequencer.sv
// conv_loop_sequencer
//
// Walks the convolution loop nest (j, k, i, m, n, l from outermost to innermost) on a start
// pulse. It drives one index tuple per non-stalled cycle to the address generator, and along
// with each tuple it flags accumulator-clear and padding. A save pulse follows each output's
// last MAC by SAVE_LAT cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   begin a layer (sampled only in IDLE)
//   stall      in   backpressure; freezes indices, state and save pipeline
//   i..l       out  8-bit index bus: out channel, out row, out col, kernel row, kernel col, in ch
//   enable     out  index bus valid this cycle
//   acc_clear  out  first MAC of a new output
//   pad        out  source pixel lies in the zero-padding border
//   en_save    out  accumulated output ready to store
//   busy       out  layer in progress (RUN or DRAIN)
//   done       out  one-cycle end-of-layer pulse
module conv_loop_sequencer #(
    parameter int unsigned CONV_DIM_IMG    = 32,
    parameter int unsigned CONV_DIM_KERNEL = 5,
    parameter int unsigned CONV_DIM_CH     = 3,
    parameter int unsigned CONV_OUT_CH     = 32,
    parameter int unsigned CONV_DIM_OUT    = 32,
    parameter int unsigned STRIDE          = 1,
    parameter int unsigned PADDING         = 2,
    parameter int unsigned SAVE_LAT        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    output logic [7:0] i,
    output logic [7:0] j,
    output logic [7:0] k,
    output logic [7:0] m,
    output logic [7:0] n,
    output logic [7:0] l,
    output logic       enable,
    output logic       acc_clear,
    output logic       pad,
    output logic       en_save,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] OutMax   = 8'(CONV_DIM_OUT - 1);
    localparam logic [7:0] OchMax   = 8'(CONV_OUT_CH - 1);
    localparam logic [7:0] KerMax   = 8'(CONV_DIM_KERNEL - 1);
    localparam logic [7:0] ChMax    = 8'(CONV_DIM_CH - 1);
    localparam logic [2:0] DrainMax = 3'(SAVE_LAT - 1);
    localparam logic [9:0] ImgDim   = 10'(CONV_DIM_IMG);
    localparam logic [9:0] Stride   = 10'(STRIDE);
    localparam logic [9:0] Pad      = 10'(PADDING);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [7:0]          i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0]          m_q, m_d, n_q, n_d, l_q, l_d;
    logic [2:0]          drain_q, drain_d;
    logic [SAVE_LAT-1:0] save_q, save_d;

    logic       i_wrap, j_wrap, k_wrap, m_wrap, n_wrap, l_wrap;
    logic       last_tuple, last_mac;
    logic [9:0] row, col;

    assign i_wrap = (i_q == OchMax);
    assign j_wrap = (j_q == OutMax);
    assign k_wrap = (k_q == OutMax);
    assign m_wrap = (m_q == KerMax);
    assign n_wrap = (n_q == KerMax);
    assign l_wrap = (l_q == ChMax);
    assign last_tuple = j_wrap & k_wrap & i_wrap & m_wrap & n_wrap & l_wrap;

    assign enable    = (state_q == StRun) & ~stall;
    assign acc_clear = enable & (m_q == 8'd0) & (n_q == 8'd0) & (l_q == 8'd0);
    assign last_mac  = enable & m_wrap & n_wrap & l_wrap;

    // Two's-complement 10-bit arithmetic; bit 9 set means the coordinate went negative.
    assign row = Stride * {2'b00, j_q} + {2'b00, m_q} - Pad;
    assign col = Stride * {2'b00, k_q} + {2'b00, n_q} - Pad;
    assign pad = enable & (row[9] | (row >= ImgDim) | col[9] | (col >= ImgDim));

    // The save pipeline freezes with the rest of the sequencer, so a pulse due under stall
    // surfaces on the first free cycle.
    assign en_save = save_q[SAVE_LAT-1] & ~stall;
    assign busy    = (state_q == StRun) | (state_q == StDrain);
    assign done    = (state_q == StDone);

    assign i = i_q;
    assign j = j_q;
    assign k = k_q;
    assign m = m_q;
    assign n = n_q;
    assign l = l_q;

    always_comb begin
        save_d = save_q;
        if (!stall) begin
            save_d    = save_q << 1;
            save_d[0] = last_mac;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        m_d = m_q;
        n_d = n_q;
        l_d = l_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    i_d = '0;
                    j_d = '0;
                    k_d = '0;
                    m_d = '0;
                    n_d = '0;
                    l_d = '0;
                end
            end
            StRun: begin
                if (!stall) begin
                    if (last_tuple) begin
                        // Indices keep the final tuple through DRAIN/DONE/IDLE.
                        state_d = StDrain;
                        drain_d = '0;
                    end else begin
                        l_d = l_wrap ? 8'd0 : l_q + 8'd1;
                        if (l_wrap) begin
                            n_d = n_wrap ? 8'd0 : n_q + 8'd1;
                            if (n_wrap) begin
                                m_d = m_wrap ? 8'd0 : m_q + 8'd1;
                                if (m_wrap) begin
                                    i_d = i_wrap ? 8'd0 : i_q + 8'd1;
                                    if (i_wrap) begin
                                        k_d = k_wrap ? 8'd0 : k_q + 8'd1;
                                        if (k_wrap) begin
                                            j_d = j_wrap ? 8'd0 : j_q + 8'd1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
            end
            StDrain: begin
                if (!stall) begin
                    if (drain_q == DrainMax) begin
                        state_d = StDone;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            drain_q <= '0;
            save_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            save_q  <= save_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            m_q     <= m_d;
            n_q     <= n_d;
            l_q     <= l_d;
        end
    end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Bench for conv_loop_sequencer. Instance "a" uses a tiny layer (K=2, CH=1, 2 out channels,
// 2x2 output, no padding, SAVE_LAT=3) for cycle-exact traces. Instance "b" keeps K=5 and
// PADDING=2 on a 4x4 image so that both padded borders are reached quickly.
module tb_conv_loop_sequencer;

    typedef struct packed {
        logic       en;
        logic [7:0] i;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] m;
        logic [7:0] n;
        logic [7:0] l;
        logic       acc_clear;
        logic       pad;
        logic       en_save;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct packed {
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] m;
        logic [7:0] n;
        logic       pad;
    } pad_vec_t;

    logic       clk = 1'b0;
    logic       reset, start, stall, start_b;
    logic [7:0] i_a, j_a, k_a, m_a, n_a, l_a;
    logic       en_a, acc_a, pad_a, save_a, busy_a, done_a;
    logic [7:0] i_b, j_b, k_b, m_b, n_b, l_b;
    logic       en_b, acc_b, pad_b, save_b, busy_b, done_b;

    obs_t     want[64];
    obs_t     base[64];
    bit       drv_start[64];
    bit       drv_stall[64];
    pad_vec_t pv[12];
    int       n_tests = 0;
    int       n_fail = 0;
    int       save_b_cnt = 0;
    int       acc_b_cnt = 0;

    always #5 clk = ~clk;

    conv_loop_sequencer #(
        .CONV_DIM_IMG(2), .CONV_DIM_KERNEL(2), .CONV_DIM_CH(1), .CONV_OUT_CH(2),
        .CONV_DIM_OUT(2), .STRIDE(1), .PADDING(0), .SAVE_LAT(3)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .i(i_a), .j(j_a), .k(k_a), .m(m_a), .n(n_a), .l(l_a),
        .enable(en_a), .acc_clear(acc_a), .pad(pad_a), .en_save(save_a),
        .busy(busy_a), .done(done_a)
    );

    conv_loop_sequencer #(
        .CONV_DIM_IMG(4), .CONV_DIM_KERNEL(5), .CONV_DIM_CH(1), .CONV_OUT_CH(1),
        .CONV_DIM_OUT(4), .STRIDE(1), .PADDING(2), .SAVE_LAT(3)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stall(1'b0),
        .i(i_b), .j(j_b), .k(k_b), .m(m_b), .n(n_b), .l(l_b),
        .enable(en_b), .acc_clear(acc_b), .pad(pad_b), .en_save(save_b),
        .busy(busy_b), .done(done_b)
    );

    always @(negedge clk) begin
        if (save_b) save_b_cnt++;
        if (acc_b) acc_b_cnt++;
    end

    function automatic obs_t sample_a();
        obs_t o;
        o.en = en_a;  o.i = i_a;  o.j = j_a;  o.k = k_a;  o.m = m_a;  o.n = n_a;  o.l = l_a;
        o.acc_clear = acc_a;  o.pad = pad_a;  o.en_save = save_a;
        o.busy = busy_a;  o.done = done_a;
        return o;
    endfunction

    task automatic check_obs(input string name, input int row, input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h want %h", name, row, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // Reference trace for one layer on instance a: row 0 is the IDLE cycle driving start,
    // rows 1..32 issue, 33..35 drain, 36 is DONE, 37 is IDLE again.
    task automatic build(input bit zero_idle);
        obs_t t;
        obs_t last;
        int   r;
        last = '0;
        last.i = 8'd1; last.j = 8'd1; last.k = 8'd1; last.m = 8'd1; last.n = 8'd1;
        for (int x = 0; x < 64; x++) begin
            want[x] = '0;
            drv_start[x] = 1'b0;
            drv_stall[x] = 1'b0;
        end
        want[0] = zero_idle ? '0 : last;
        drv_start[0] = 1'b1;
        r = 1;
        for (int jj = 0; jj < 2; jj++)
            for (int kk = 0; kk < 2; kk++)
                for (int ii = 0; ii < 2; ii++)
                    for (int mm = 0; mm < 2; mm++)
                        for (int nn = 0; nn < 2; nn++)
                            for (int ll = 0; ll < 1; ll++) begin
                                t = '0;
                                t.en = 1'b1;
                                t.i = 8'(ii); t.j = 8'(jj); t.k = 8'(kk);
                                t.m = 8'(mm); t.n = 8'(nn); t.l = 8'(ll);
                                t.acc_clear = (mm == 0 && nn == 0 && ll == 0);
                                t.pad = (jj + mm >= 2) || (kk + nn >= 2);
                                t.busy = 1'b1;
                                want[r] = t;
                                r++;
                            end
        for (int x = 33; x <= 35; x++) begin
            want[x] = last;
            want[x].busy = 1'b1;
        end
        want[36] = last;
        want[36].done = 1'b1;
        want[37] = last;
        for (int x = 1; x <= 32; x++)
            if (want[x].m == 8'd1 && want[x].n == 8'd1 && want[x].l == 8'd0)
                want[x + 3].en_save = 1'b1;
    endtask

    task automatic run_rows(input string name, input int nrows, output int en_cnt,
                            output int save_cnt);
        obs_t got;
        en_cnt = 0;
        save_cnt = 0;
        for (int r = 0; r < nrows; r++) begin
            @(negedge clk);
            start = drv_start[r];
            stall = drv_stall[r];
            #1;
            got = sample_a();
            if (got.en) en_cnt++;
            if (got.en_save) save_cnt++;
            check_obs(name, r, got, want[r]);
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec, sc, cnt;
        bit found;
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        start_b = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check_obs("reset_a", 0, sample_a(), '0);
        check_int("reset_b", int'({en_b, busy_b, done_b, pad_b, save_b}), 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: plain layer
        build(1'b1);
        run_rows("layer", 38, ec, sc);
        check_int("layer_enable_cnt", ec, 32);
        check_int("layer_save_cnt", sc, 8);

        // 3: four stall cycles right after the first last_mac issue (row 4)
        build(1'b0);
        for (int x = 0; x < 64; x++) base[x] = want[x];
        for (int r = 0; r < 42; r++) begin
            if (r <= 4) begin
                want[r] = base[r];
            end else if (r <= 8) begin
                want[r] = base[5];
                want[r].en = 1'b0;
                want[r].acc_clear = 1'b0;
                want[r].pad = 1'b0;
                want[r].en_save = 1'b0;
                drv_stall[r] = 1'b1;
            end else begin
                want[r] = base[r - 4];
            end
        end
        run_rows("stall", 42, ec, sc);
        check_int("stall_enable_cnt", ec, 32);
        check_int("stall_save_cnt", sc, 8);

        // 4: start pokes in RUN, DRAIN and DONE are ignored
        build(1'b0);
        drv_start[11] = 1'b1;
        drv_start[34] = 1'b1;
        drv_start[36] = 1'b1;
        run_rows("start_busy", 38, ec, sc);

        // 5: reset after ten issues
        @(negedge clk);
        start = 1'b1;
        cnt = 0;
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (en_a) cnt++;
        end
        check_int("pre_reset_issues", cnt, 10);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_obs("reset_async", 0, sample_a(), '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_obs("reset_release", 0, sample_a(), '0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (en_a || save_a || done_a || busy_a) cnt++;
        end
        check_int("post_reset_quiet", cnt, 0);
        build(1'b1);
        run_rows("after_reset", 38, ec, sc);

        // 6: back-to-back layers, second start in the cycle after done
        build(1'b0);
        run_rows("b2b_first", 37, ec, sc);
        build(1'b0);
        run_rows("b2b_second", 38, ec, sc);
        check_int("b2b_enable_cnt", ec, 32);

        // 2: padding borders on instance b (4x4 image, K=5, PADDING=2)
        pv[0]  = '{j: 8'd0, k: 8'd0, m: 8'd0, n: 8'd0, pad: 1'b1};
        pv[1]  = '{j: 8'd0, k: 8'd0, m: 8'd1, n: 8'd3, pad: 1'b1};
        pv[2]  = '{j: 8'd0, k: 8'd0, m: 8'd2, n: 8'd2, pad: 1'b0};
        pv[3]  = '{j: 8'd0, k: 8'd0, m: 8'd3, n: 8'd4, pad: 1'b0};
        pv[4]  = '{j: 8'd0, k: 8'd0, m: 8'd4, n: 8'd1, pad: 1'b1};
        pv[5]  = '{j: 8'd1, k: 8'd2, m: 8'd0, n: 8'd4, pad: 1'b1};
        pv[6]  = '{j: 8'd1, k: 8'd2, m: 8'd2, n: 8'd0, pad: 1'b0};
        pv[7]  = '{j: 8'd3, k: 8'd3, m: 8'd0, n: 8'd0, pad: 1'b0};
        pv[8]  = '{j: 8'd3, k: 8'd3, m: 8'd2, n: 8'd2, pad: 1'b0};
        pv[9]  = '{j: 8'd3, k: 8'd3, m: 8'd2, n: 8'd3, pad: 1'b1};
        pv[10] = '{j: 8'd3, k: 8'd3, m: 8'd3, n: 8'd0, pad: 1'b1};
        pv[11] = '{j: 8'd3, k: 8'd3, m: 8'd4, n: 8'd4, pad: 1'b1};
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int v = 0; v < 12; v++) begin
            found = 1'b0;
            for (int c = 0; c < 600; c++) begin
                #1;
                if (en_b && i_b == 8'd0 && l_b == 8'd0 && j_b == pv[v].j && k_b == pv[v].k &&
                    m_b == pv[v].m && n_b == pv[v].n) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!found) begin
                n_tests++;
                n_fail++;
                $display("FAIL pad_reach vec %0d: tuple not issued within budget, want j=%0d k=%0d m=%0d n=%0d",
                         v, pv[v].j, pv[v].k, pv[v].m, pv[v].n);
            end else begin
                check_int($sformatf("pad_vec%0d", v), int'(pad_b), int'(pv[v].pad));
                @(negedge clk);
            end
        end
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            #1;
            if (done_b) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_int("pad_done_seen", int'(found), 1);
        check_int("pad_done_busy", int'(busy_b), 0);
        check_int("pad_save_cnt", save_b_cnt, 16);
        check_int("pad_acc_clear_cnt", acc_b_cnt, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_loop_sequencer.md
# conv_loop_sequencer

Loop-index sequencer for the convolution datapath. On a `start` pulse it walks the full convolution loop nest and drives the index bus (`i`, `j`, `k`, `m`, `n`, `l`) plus `enable` and `en_save` into the convolution address generator. Along the same pipeline it emits accumulator-clear and padding-zero flags. It sits between the layer controller (start, done, stall) and the address generator / MAC array, and is the producer of every index the address generator consumes.

## Interface
- `CONV_DIM_IMG`, 32: input feature-map height/width.
- `CONV_DIM_KERNEL`, 5: kernel height/width (K).
- `CONV_DIM_CH`, 3: input channels (CH).
- `CONV_OUT_CH`, 32: output channels.
- `CONV_DIM_OUT`, 32: output height/width.
- `STRIDE`, 1: convolution stride.
- `PADDING`, 2: zero padding on each border.
- `SAVE_LAT`, 3: non-stalled cycles from the last MAC issue of an output to its `en_save` (range 1..7).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a layer; sampled only in IDLE.
- `stall` in 1: backpressure; freezes the sequencer while high.
- `i`, `j`, `k`, `m`, `n`, `l` out 8 each: output channel, output row, output column, kernel row, kernel column, input channel.
- `enable` out 1: index bus valid this cycle (address generator captures).
- `acc_clear` out 1: first MAC of a new output, qualified by `enable`.
- `pad` out 1: current source pixel lies in the padding region, qualified by `enable`.
- `en_save` out 1: one-cycle pulse; the accumulated output is ready to store.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at end of layer.

## Operation
- States:
  - IDLE: `start`=1 → RUN with all indices 0.
  - RUN: the cycle issuing the final index tuple, not stalled → DRAIN.
  - DRAIN: lasts SAVE_LAT non-stalled cycles → DONE.
  - DONE: lasts one cycle → IDLE.
- Loop order, outermost to innermost: `j`, `k`, `i`, `m`, `n`, `l`.
  - Each counter wraps to 0 at its limit and carries into the next outer one.
  - Limits: `j`,`k` < CONV_DIM_OUT; `i` < CONV_OUT_CH; `m`,`n` < K; `l` < CH.
- RUN issue rate:
  - One tuple per non-stalled cycle, with `enable`=1.
  - Total issue cycles = CONV_DIM_OUT² · CONV_OUT_CH · K² · CH.
- `acc_clear`=`enable` & (`m`==0 & `n`==0 & `l`==0).
- `last_mac` (internal) = `enable` & (`m`==K-1 & `n`==K-1 & `l`==CH-1).
  - It enters a SAVE_LAT-deep shift register.
  - `en_save` is the register's output.
- `pad` computation:
  - row = STRIDE·`j`+`m`−PADDING and col = STRIDE·`k`+`n`−PADDING, both evaluated as 10-bit signed.
  - `pad`=1 if row<0, row≥CONV_DIM_IMG, col<0 or col≥CONV_DIM_IMG.
  - `pad` is combinational from the registered indices.
- Stall behaviour:
  - Indices, state and the save shift register all hold.
  - `enable`, `acc_clear`, `pad` and `en_save` are forced 0.
  - A save pulse due under stall is emitted on the first non-stalled cycle.
- `start` in RUN, DRAIN or DONE is ignored; there is no queued restart.
- In IDLE, DONE and DRAIN: indices hold their last value, `enable`=0.

## Timing
- Reset values: indices 0, `enable` 0, `acc_clear` 0, `pad` 0, `en_save` 0, `busy` 0, `done` 0, state IDLE, shift register cleared.
- Reset asserted mid-layer aborts immediately. No `done` is produced, and no pending `en_save` is emitted after release.
- Start latency:
  - `start` sampled high at edge t (state IDLE).
  - From t+1: `enable`=1, indices all 0, `acc_clear`=1, `busy`=1.
- Save latency: `last_mac` in issue cycle c → `en_save` high in cycle c+SAVE_LAT, with no stall in between.
- Last output: its `en_save` falls in the final DRAIN cycle.
- Done timing:
  - `done` is high for one cycle, the cycle after DRAIN ends.
  - `busy` is 0 in that cycle.
  - A `start` in the cycle after DONE is accepted.
- All registered outputs change only on rising `clk` or on asserting `reset`.

## Test plan
1. Small config, no stall:
   - Config: K=2, CH=1, CONV_OUT_CH=2, CONV_DIM_OUT=2, CONV_DIM_IMG=2, PADDING=0, SAVE_LAT=3.
   - Stimulus: `start` pulse.
   - Required response: exactly 32 `enable` cycles; tuple order matches loop nest (first `l`, then `n`…); 8 `en_save` pulses, each 3 cycles after an (m,n,l)=(1,1,0) issue; `done` 4 cycles after the last issue.
2. Padding:
   - Config: defaults (K=5, PADDING=2).
   - Required response: at j=k=0, `pad`=1 for m<2 or n<2 and 0 for m=n=2. At j=k=31, `pad`=1 for m>2 or n>2.
3. Stall:
   - Stimulus: `stall` held 4 cycles starting on the cycle after a `last_mac` issue.
   - Required response: indices frozen; `enable`, `en_save` = 0 during the stall; `en_save` appears 2 non-stalled cycles after `stall` falls; total `enable` count unchanged.
4. Start while busy:
   - Stimulus: `start` pulsed mid-RUN and in DRAIN.
   - Required response: no restart; tuple sequence and `done` timing identical to test 1.
5. Reset mid-layer:
   - Stimulus: `reset` low for 1 cycle after 10 issues.
   - Required response: all outputs 0 asynchronously; no `en_save` or `done` afterwards; a fresh `start` reproduces the full test-1 sequence from index 0.
6. Back-to-back layers:
   - Stimulus: `start` in the cycle after `done`.
   - Required response: accepted; second layer is cycle-identical to the first.
